// File: rtl/sw_debounce_pkg.sv
// Shared switch-bank constants for the debounce stage and its consumers.
package sw_debounce_pkg;

  // Debounce window used in simulation builds (short, keeps runs fast)
  localparam int SW_DEBOUNCE_CYCLES_SIM   = 4;
  // Debounce window on the board: 10 ms at 50 MHz
  localparam int SW_DEBOUNCE_CYCLES_BOARD = 500000;
  // Position of the encoder enable switch within the switch vector
  localparam int SW_EN_BIT                = 8;

  // True when a stability window of 'cycles' can be counted in a cnt_w-bit counter
  function automatic bit stable_cycles_ok(input int cycles, input int cnt_w);
    longint lim;
    lim = longint'(1) << cnt_w;
    return (cycles >= 1) && (longint'(cycles) <= lim);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, accepted level
// and single-cycle rise/fall strobes.
module debounce_bit #(
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);

  // Count value reached on the last mismatching edge before acceptance
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  logic w_mismatch;
  logic w_accept;

  assign w_mismatch = r_s2 ^ r_stb;
  assign w_accept   = w_mismatch && (r_cnt == LAST);

  // Bring the asynchronous switch level into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive mismatching cycles; any return to the old level restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else if (!w_mismatch) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_stb <= r_s2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Edge strobes are high for the one cycle after the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept & r_s2;
      r_fall <= w_accept & ~r_s2;
    end
  end

  assign o_stable = r_stb;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  // Combinational acceptance so the top can register 'changed' alongside the strobes
  assign o_accept = w_accept;

endmodule

// File: rtl/sw_debounce.sv
// Switch-bank conditioning: per-bit debounce plus a registered change strobe.
// Define SW_DEBOUNCE_SIM to default to the short simulation window.
`ifdef SW_DEBOUNCE_SIM
  `define SW_DEBOUNCE_DEFAULT_CYCLES sw_debounce_pkg::SW_DEBOUNCE_CYCLES_SIM
`else
  `define SW_DEBOUNCE_DEFAULT_CYCLES sw_debounce_pkg::SW_DEBOUNCE_CYCLES_BOARD
`endif

module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 9,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = `SW_DEBOUNCE_DEFAULT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Reject a window the per-bit counter cannot represent
  if (!stable_cycles_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_window
    $fatal(1, "sw_debounce: STABLE_CYCLES must be in 1..2**CNT_W");
  end

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_accept;
  logic             r_changed;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (sw_raw[gi]),
      .o_stable (w_stable[gi]),
      .o_rise   (w_rise[gi]),
      .o_fall   (w_fall[gi]),
      .o_accept (w_accept[gi])
    );
  end

  // One change pulse per accepting edge, however many bits accepted together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_accept;
    end
  end

  assign sw_stable = w_stable;
  assign rise      = w_rise;
  assign fall      = w_fall;
  assign changed   = r_changed;

endmodule
